// File: rtl/instruction_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_mem
// Brief    : Instruction memory with 1-cycle fetch, credit-based request flow
//            control and an in-order response FIFO; program-load write port.
// Revision : 1.0
// ============================================================================
module instruction_fetch_mem #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int IMEM_SIZE = 128,
  parameter int RSP_DEPTH = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [ADDR_BITS-1:0]         req_addr,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_BITS-1:0]         rsp_instr,
  output logic                         rsp_err,
  input  logic                         flush,
  input  logic                         prog_en,
  input  logic [$clog2(IMEM_SIZE)-1:0] prog_addr,
  input  logic [DATA_BITS-1:0]         prog_data
);

  localparam int WB = $clog2(DATA_BITS / 8);
  localparam int IB = $clog2(IMEM_SIZE);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  localparam logic [PW-1:0] c_last_ptr = PW'(RSP_DEPTH - 1);
  localparam logic [CW:0]   c_depth    = (CW + 1)'(RSP_DEPTH);

  logic [DATA_BITS-1:0] mem_q        [IMEM_SIZE];
  logic [DATA_BITS-1:0] fifo_instr_q [RSP_DEPTH];
  logic                 fifo_err_q   [RSP_DEPTH];
  logic [DATA_BITS-1:0] rd_data_q;
  logic                 inflight_q;
  logic                 inflight_err_q;
  logic                 ready_en_q;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;

  logic                 w_misaligned;
  logic                 w_out_of_range;
  logic                 w_fault;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic [IB-1:0]        w_idx;
  logic [CW:0]          w_used;

  generate
    if (WB > 0) begin : g_align
      assign w_misaligned = |req_addr[WB-1:0];
    end else begin : g_no_align
      assign w_misaligned = 1'b0;
    end
    if (ADDR_BITS > WB + IB) begin : g_range
      assign w_out_of_range = |req_addr[ADDR_BITS-1:WB+IB];
    end else begin : g_no_range
      assign w_out_of_range = 1'b0;
    end
  endgenerate

  assign w_idx   = req_addr[WB+IB-1:WB];
  assign w_fault = w_misaligned | w_out_of_range;

  // Credits count both queued and in-flight entries so a push never overflows.
  assign w_used    = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign req_ready = ready_en_q && !flush && (w_used < c_depth);
  assign w_accept  = req_valid && req_ready;

  assign rsp_valid = (count_q != '0);
  assign w_push    = inflight_q && !flush;
  assign w_pop     = rsp_valid && rsp_ready && !flush;
  assign rsp_instr = rsp_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign rsp_err   = rsp_valid & fifo_err_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_push) wr_ptr_d = (wr_ptr_q == c_last_ptr) ? '0 : wr_ptr_q + 1'b1;
    if (w_pop)  rd_ptr_d = (rd_ptr_q == c_last_ptr) ? '0 : rd_ptr_q + 1'b1;
    if (w_push && !w_pop)      count_d = count_q + 1'b1;
    else if (!w_push && w_pop) count_d = count_q - 1'b1;
  end

  // Old RAM data is captured on a same-word collision (read-before-write).
  always_ff @(posedge clk) begin
    if (prog_en) mem_q[prog_addr] <= prog_data;
    if (w_accept) rd_data_q <= w_fault ? '0 : mem_q[w_idx];
    if (w_push) begin
      fifo_instr_q[wr_ptr_q] <= rd_data_q;
      fifo_err_q[wr_ptr_q]   <= inflight_err_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q     <= 1'b0;
      inflight_q     <= 1'b0;
      inflight_err_q <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      ready_en_q <= 1'b1;
      if (flush) begin
        inflight_q     <= 1'b0;
        inflight_err_q <= 1'b0;
        wr_ptr_q       <= '0;
        rd_ptr_q       <= '0;
        count_q        <= '0;
      end else begin
        inflight_q     <= w_accept;
        inflight_err_q <= w_accept & w_fault;
        wr_ptr_q       <= wr_ptr_d;
        rd_ptr_q       <= rd_ptr_d;
        count_q        <= count_d;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch_mem
// Brief    : Directed self-checking bench for instruction_fetch_mem.
// Revision : 1.0
// ============================================================================
module tb_instruction_fetch_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic        rsp_err;
  logic        flush;
  logic        prog_en;
  logic [6:0]  prog_addr;
  logic [31:0] prog_data;

  int vectors     = 0;
  int miscompares = 0;

  instruction_fetch_mem #(
    .DATA_BITS(32), .ADDR_BITS(32), .IMEM_SIZE(128), .RSP_DEPTH(3)
  ) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_err(rsp_err),
    .flush(flush),
    .prog_en(prog_en), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic [31:0] instr, input logic err);
    check({tag, "_v"}, rsp_valid, 1'b1);
    check({tag, "_i"}, rsp_instr, instr);
    check({tag, "_e"}, rsp_err, err);
  endtask

  logic [31:0] c_words [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  int  acc;
  logic took;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b0;
    flush = 1'b0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    tick(); tick();
    check("rst_ready", req_ready, 1'b0);
    check("rst_valid", rsp_valid, 1'b0);
    check("rst_instr", rsp_instr, 32'h0);
    check("rst_err",   rsp_err,   1'b0);
    rst = 1'b0;
    #1;
    check("ready_before_edge", req_ready, 1'b0);
    tick();
    check("ready_after_edge", req_ready, 1'b1);

    for (int i = 0; i < 4; i++) begin
      prog_en = 1'b1; prog_addr = 7'(i); prog_data = c_words[i];
      tick();
    end
    prog_en = 1'b0;

    // Back-to-back aligned fetches, consumer always ready.
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0;
    check("b2b_ready0", req_ready, 1'b1);
    tick();
    check("b2b_lat", rsp_valid, 1'b0);
    for (int i = 1; i < 4; i++) begin
      req_addr = 32'(i * 4);
      check("b2b_ready", req_ready, 1'b1);
      tick();
      check_rsp("b2b", c_words[i-1], 1'b0);
    end
    req_valid = 1'b0;
    tick();
    check_rsp("b2b_last", c_words[3], 1'b0);
    tick();
    check("b2b_empty", rsp_valid, 1'b0);

    // Faulting requests interleaved with a good one.
    req_valid = 1'b1; req_addr = 32'h6;
    tick();
    req_addr = 32'h200;
    tick();
    check_rsp("mis", 32'h0, 1'b1);
    req_addr = 32'h4;
    tick();
    check_rsp("oor", 32'h0, 1'b1);
    req_valid = 1'b0;
    tick();
    check_rsp("good", 32'h22222222, 1'b0);
    tick();
    check("fault_empty", rsp_valid, 1'b0);

    // Backpressure: exactly RSP_DEPTH accepts.
    rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      took = req_ready;
      if (took) acc++;
      tick();
      if (took) req_addr = req_addr + 32'h4;
    end
    check("bp_accepts", acc, 3);
    check("bp_ready", req_ready, 1'b0);
    check_rsp("bp_head", 32'h11111111, 1'b0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    #1;
    check("bp_no_comb", req_ready, 1'b0);
    tick();
    check("bp_reassert", req_ready, 1'b1);
    check_rsp("bp_d1", 32'h22222222, 1'b0);
    tick();
    check_rsp("bp_d2", 32'h33333333, 1'b0);
    tick();
    check("bp_empty", rsp_valid, 1'b0);

    // Program write colliding with a read of the same word.
    prog_en = 1'b1; prog_addr = 7'd2; prog_data = 32'hDEADBEEF;
    req_valid = 1'b1; req_addr = 32'h8;
    tick();
    prog_en = 1'b0; req_valid = 1'b0;
    tick();
    check_rsp("rbw_old", 32'h33333333, 1'b0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check_rsp("rbw_new", 32'hDEADBEEF, 1'b0);
    tick();

    // Flush with two queued and one in flight.
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_addr = 32'h8; tick();
    check("fl_pre_valid", rsp_valid, 1'b1);
    flush = 1'b1; req_addr = 32'hC;
    #1;
    check("fl_ready", req_ready, 1'b0);
    tick();
    flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    check("fl_valid0", rsp_valid, 1'b0);
    tick();
    check("fl_no_stale", rsp_valid, 1'b0);
    req_valid = 1'b1; req_addr = 32'hC;
    tick();
    req_valid = 1'b0;
    check("fl_no_stale2", rsp_valid, 1'b0);
    tick();
    check_rsp("fl_next", 32'h44444444, 1'b0);
    tick();

    // Asynchronous reset mid-stream.
    rsp_ready = 1'b0; req_valid = 1'b1;
    req_addr = 32'h0; tick();
    req_addr = 32'h4; tick();
    req_valid = 1'b0;
    check("ar_pre_valid", rsp_valid, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_ready", req_ready, 1'b0);
    check("ar_valid", rsp_valid, 1'b0);
    check("ar_instr", rsp_instr, 32'h0);
    check("ar_err",   rsp_err,   1'b0);
    tick();
    rst = 1'b0;
    tick();
    rsp_ready = 1'b1;
    check("ar_queue_gone", rsp_valid, 1'b0);
    req_valid = 1'b1; req_addr = 32'h4;
    tick();
    req_valid = 1'b0;
    tick();
    check_rsp("ar_ram_kept", 32'h22222222, 1'b0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_mem.md
INSTRUCTION_FETCH_MEM -- requirements
Module: instruction_fetch_mem

Interface
REQ-001 Parameter DATA_BITS, default 32, meaning instruction width in bits; a multiple of 8.
REQ-002 Parameter ADDR_BITS, default 32, meaning width of the request address.
REQ-003 Parameter IMEM_SIZE, default 128, meaning depth in words; a power of two, >= 2.
REQ-004 Parameter RSP_DEPTH, default 3, meaning response FIFO entries; >= 2.
REQ-005 Derived: WB = log2(DATA_BITS/8) byte-offset bits; IB = log2(IMEM_SIZE) index bits.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 rst  in  1  reset; asynchronous, active-high.
REQ-008 req_valid  in  1  fetch request present.
REQ-009 req_ready  out  1  block can accept a request this cycle.
REQ-010 req_addr  in  ADDR_BITS  byte address of the instruction.
REQ-011 rsp_valid  out  1  FIFO head holds a response.
REQ-012 rsp_ready  in  1  consumer takes the head this cycle.
REQ-013 rsp_instr  out  DATA_BITS  instruction at the FIFO head.
REQ-014 rsp_err  out  1  head response is a fault (misaligned or out of range).
REQ-015 flush  in  1  discard all pending and in-flight fetches (branch redirect).
REQ-016 prog_en  in  1  write enable for the program-load port.
REQ-017 prog_addr  in  IB  word index to write.
REQ-018 prog_data  in  DATA_BITS  word to write.

Function
REQ-019 Storage: IMEM_SIZE x DATA_BITS synchronous RAM; contents are not initialised and are not altered by rst or flush.
REQ-020 Accept: a request is accepted when req_valid && req_ready at a rising edge.
REQ-021 Read latency: 1 cycle; the accepted request occupies an in-flight stage for one cycle, then enters the FIFO tail.
REQ-022 Word index = req_addr[WB+IB-1:WB].
REQ-023 Fault: misaligned if req_addr[WB-1:0] != 0; out of range if any req_addr bit above WB+IB-1 is 1.
REQ-024 A faulting request does not read the RAM; its entry carries rsp_err=1 and rsp_instr=0.
REQ-025 Non-faulting entries carry rsp_err=0 and the RAM word.
REQ-026 Credit rule: req_ready = !flush && (fifo_count + inflight) < RSP_DEPTH; no combinational path from rsp_ready or req_valid to req_ready.
REQ-027 Throughput: with rsp_ready held high and RSP_DEPTH >= 3, one request is accepted and one response is delivered every cycle.
REQ-028 FIFO: responses leave strictly in acceptance order; a pop occurs when rsp_valid && rsp_ready.
REQ-029 Simultaneous push and pop leave fifo_count unchanged; pop on an empty FIFO and push on a full FIFO cannot occur, by REQ-026.
REQ-030 rsp_valid = (fifo_count != 0); rsp_instr and rsp_err are 0 whenever rsp_valid = 0.
REQ-031 Pointers wrap modulo RSP_DEPTH; RSP_DEPTH need not be a power of two.
REQ-032 Program port: when prog_en = 1, prog_data is written to RAM[prog_addr] at the edge.
REQ-033 Write/read collision: a read of the same word in the same cycle returns the old data (read-before-write).
REQ-034 Flush: when flush = 1 at an edge, fifo_count, pointers and inflight clear; no request is accepted that cycle.
REQ-035 rsp_ready is ignored during flush; a concurrent prog_en write still completes.

Reset
REQ-036 While rst = 1: req_ready=0, rsp_valid=0, rsp_instr=0, rsp_err=0, fifo_count=0, inflight=0, pointers=0.
REQ-037 req_ready rises on the first edge after rst deasserts.
REQ-038 Reset mid-operation discards in-flight and queued responses without further handshakes; RAM contents are retained.

Verification
REQ-039 Load 0x11111111..0x44444444 at indices 0..3, then request addrs 0x0,0x4,0x8,0xC back-to-back with rsp_ready=1 -> 4 responses in order, one per cycle, first 2 cycles after the first accept, rsp_err=0.
REQ-040 Request 0x6 (misaligned), then 0x200 (index 128, out of range), then 0x4 -> responses (err=1, 0), (err=1, 0), (err=0, 0x22222222), in order.
REQ-041 Hold rsp_ready=0 and req_valid=1 -> exactly RSP_DEPTH accepts, then req_ready=0; release rsp_ready -> the 3 responses drain in order, and req_ready reasserts the cycle after the first pop.
REQ-042 prog_en writes 0xDEADBEEF to index 2 in the same cycle a read of 0x8 is accepted -> response 0x33333333; a following read of 0x8 -> 0xDEADBEEF.
REQ-043 With 2 entries queued and 1 in flight, assert flush for one cycle with req_valid=1 -> req_ready=0 that cycle, rsp_valid=0 next cycle, no stale response ever appears, and the next request returns the correct data.
REQ-044 Assert rst asynchronously mid-stream -> all outputs 0 immediately; after release, RAM still holds the loaded words.
